weight_loader: RTL and testbench

Upstream feeder for the weight buffer. Accepts a column-major stream of weights over a valid/ready handshake and steers each beat into the per-column weight FIFO (one-hot `wr_en`, broadcast `wr_data`). Once all columns are filled, it issues the `read` strobe that starts skewed weight delivery into the systolic array, then signals completion. It sits between the weight DMA/memory interface and the weight buffer.

---
 rtl/weight_loader_if.sv | 23 ++
 rtl/weight_loader.sv | 89 ++++++++
 tb/tb_weight_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/weight_loader_if.sv
// weight_loader_if: load request, weight stream and per-column FIFO write/read bus of the weight loader.
interface weight_loader_if #(
  parameter int SYS_COLS = 4,
  parameter int DW       = 8,
  parameter int DEPTH    = 8,
  parameter int RW       = $clog2(DEPTH + 1)
);
  logic                   start;
  logic [RW-1:0]          num_rows;
  logic                   s_valid;
  logic [DW-1:0]          s_data;
  logic                   s_ready;
  logic [SYS_COLS-1:0]    wr_en;
  logic [SYS_COLS*DW-1:0] wr_data;
  logic                   read;
  logic                   busy;
  logic                   done;
  logic                   err;
  modport master (output start, num_rows, s_valid, s_data,
                  input  s_ready, wr_en, wr_data, read, busy, done, err);
  modport slave  (input  start, num_rows, s_valid, s_data,
                  output s_ready, wr_en, wr_data, read, busy, done, err);
endinterface

// File: rtl/weight_loader.sv
// weight_loader: steers a column-major weight stream into per-column FIFOs, then issues R read strobes.
module weight_loader #(
  parameter int SYS_COLS = 4,
  parameter int DW       = 8,
  parameter int DEPTH    = 8,
  parameter int RW       = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst,
  weight_loader_if.slave bus
);
  localparam int CW = SYS_COLS > 1 ? $clog2(SYS_COLS) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, ISSUE, DONE} state_e;
  state_e                 state_q, state_d;
  logic [RW-1:0]          r_q, r_d, row_q, row_d, cnt_q, cnt_d;
  logic [CW-1:0]          col_q, col_d;
  logic [SYS_COLS-1:0]    wr_en_q, wr_en_d;
  logic [SYS_COLS*DW-1:0] wr_data_q, wr_data_d;
  logic                   err_q, err_d;
  logic                   bad_req, last_row, last_col;
  always_comb begin
    bad_req   = bus.num_rows == '0 || int'(bus.num_rows) > DEPTH;
    last_row  = row_q == r_q - 1'b1;
    last_col  = col_q == CW'(SYS_COLS - 1);
    state_d   = state_q;
    r_d       = r_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        err_d   = bad_req;
        state_d = bad_req ? IDLE : LOAD;
        r_d     = bad_req ? r_q : bus.num_rows;
        row_d   = '0;
        col_d   = '0;
      end
      LOAD: if (bus.s_valid) begin
        wr_en_d   = SYS_COLS'(1) << col_q;
        wr_data_d = {SYS_COLS{bus.s_data}};
        row_d     = last_row ? '0 : row_q + 1'b1;
        col_d     = last_row ? (last_col ? '0 : col_q + 1'b1) : col_q;
        state_d   = last_row && last_col ? SETTLE : LOAD;
      end
      // the final write lands during SETTLE, so the first read never races it
      SETTLE: begin
        state_d = ISSUE;
        cnt_d   = r_q;
      end
      ISSUE: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == RW'(1) ? DONE : ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      r_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end
  assign bus.s_ready = state_q == LOAD;
  assign bus.read    = state_q == ISSUE;
  assign bus.busy    = state_q != IDLE;
  assign bus.done    = state_q == DONE;
  assign bus.err     = err_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: table-driven loads plus reset, re-start and random-stall sequences against a column scoreboard.
module tb_weight_loader;
  localparam int SC = 4, DW = 8, DEPTH = 8, RW = $clog2(DEPTH + 1);
  typedef struct {int rows; int mode; bit rej; bit poke;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  weight_loader_if #(.SYS_COLS(SC), .DW(DW), .DEPTH(DEPTH), .RW(RW)) bus ();
  weight_loader #(.SYS_COLS(SC), .DW(DW), .DEPTH(DEPTH), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc, done_cyc, last_wr_cyc, first_rd, last_rd;
  int reads, dones, errs, busy_cyc, overlap, bad_onehot, bad_lanes;
  logic [DW-1:0] got[SC][$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic clear();
    foreach (got[c]) got[c].delete();
    reads = 0; dones = 0; errs = 0; busy_cyc = 0; overlap = 0; bad_onehot = 0; bad_lanes = 0;
    start_cyc = -1; done_cyc = -1; last_wr_cyc = -1; first_rd = -1; last_rd = -1;
  endtask
  always @(negedge clk) begin
    cyc++;
    if (bus.start && !bus.busy && !rst) start_cyc = cyc;
    if (|bus.wr_en) begin
      last_wr_cyc = cyc;
      if (!$onehot(bus.wr_en)) bad_onehot++;
      for (int c = 0; c < SC; c++) begin
        if (bus.wr_en[c]) got[c].push_back(bus.wr_data[c*DW +: DW]);
        if (bus.wr_data[c*DW +: DW] != bus.wr_data[DW-1:0]) bad_lanes++;
      end
    end
    if (bus.read) begin
      reads++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      if (|bus.wr_en) overlap++;
    end
    if (bus.done) begin dones++; done_cyc = cyc; end
    if (bus.err) errs++;
    if (bus.busy) busy_cyc++;
  end
  task automatic load(input int rows, input int mode, input int base, input bit rej, input bit poke);
    int n, b, t, bad, total;
    logic hs;
    logic [DW-1:0] e;
    clear();
    n = SC * rows;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_rows = RW'(rows);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (rej) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rej_err_pulses", errs, 1);
      chk("rej_busy_cycles", busy_cyc, 0);
      chk("rej_done", dones, 0);
      return;
    end
    b = 0;
    t = 0;
    while (b < n && t < 1000) begin
      bus.start    = poke && t == 4;
      bus.num_rows = RW'(poke && t == 4 ? 5 : rows);
      bus.s_valid  = mode == 0 ? 1'b1 : mode == 1 ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      bus.s_data   = DW'(base + b);
      @(negedge clk);
      hs = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (hs) b++;
      t++;
    end
    bus.s_valid = 1'b0;
    bus.start   = 1'b0;
    if (poke) begin
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.num_rows = RW'(2);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    t = 0;
    while (dones == 0 && t < 200) begin @(posedge clk); t++; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    bad = 0;
    total = 0;
    for (int c = 0; c < SC; c++) begin
      total += got[c].size();
      for (int i = 0; i < rows; i++) begin
        e = DW'(base + c * rows + i);
        if (i >= got[c].size() || got[c][i] != e) bad++;
      end
    end
    chk("beats_written", total, n);
    chk("column_order_errors", bad, 0);
    chk("read_cycles", reads, rows);
    chk("read_contiguous", last_rd - first_rd + 1, rows);
    chk("settle_gap", first_rd - last_wr_cyc, 1);
    chk("done_after_read", done_cyc - last_rd, 1);
    chk("done_pulses", dones, 1);
    chk("err_pulses", errs, 0);
    chk("read_wr_overlap", overlap, 0);
    chk("wr_en_onehot", bad_onehot, 0);
    chk("wr_data_lanes", bad_lanes, 0);
    chk("idle_after_done", 32'(bus.busy), 0);
    if (mode == 0) chk("start_to_done", done_cyc - start_cyc + 1, n + rows + 3);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
    chk({tag, "_read"}, 32'(bus.read), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask
  initial begin
    vec_t vecs[10];
    vecs[0] = '{3, 0, 1'b0, 1'b0};
    vecs[1] = '{3, 1, 1'b0, 1'b0};
    vecs[2] = '{DEPTH, 0, 1'b0, 1'b0};
    vecs[3] = '{DEPTH + 1, 0, 1'b1, 1'b0};
    vecs[4] = '{0, 0, 1'b1, 1'b0};
    vecs[5] = '{1, 0, 1'b0, 1'b0};
    vecs[6] = '{1, 1, 1'b0, 1'b0};
    vecs[7] = '{5, 2, 1'b0, 1'b0};
    vecs[8] = '{3, 0, 1'b0, 1'b1};
    vecs[9] = '{15, 0, 1'b1, 1'b0};
    bus.start = 1'b1;
    bus.num_rows = RW'(3);
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst = 1'b0;
    foreach (vecs[i]) load(vecs[i].rows, vecs[i].mode, 1 + 17 * i, vecs[i].rej, vecs[i].poke);
    clear();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_rows = RW'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.s_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      bus.s_data = DW'(100 + b);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus.s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midrst");
    chk("midrst_beats", got[0].size() + got[1].size(), 5);
    @(posedge clk); #1;
    rst = 1'b0;
    load(2, 0, 50, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) load($urandom_range(1, DEPTH), 2, $urandom_range(0, 255), 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
